// File: rtl/data_cache_store_buffer.sv
// In-order store buffer between the store unit and the data cache (port 0).
// Define STORE_BUFFER_FORWARDING_EN to forward WORD stores to matching loads.
module data_cache_store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  stu_valid_i,
  input  logic [ADDR_WIDTH-1:0] stu_address_i,
  input  logic [DATA_WIDTH-1:0] stu_data_i,
  input  logic [1:0]            stu_width_i,
  output logic                  stu_ready_o,
  output logic                  cache_write_o,
  output logic [ADDR_WIDTH-1:0] cache_address_o,
  output logic [DATA_WIDTH-1:0] cache_data_o,
  output logic [1:0]            cache_width_o,
  input  logic                  cache_done_i,
  input  logic                  ldu_read_i,
  input  logic [ADDR_WIDTH-1:0] ldu_address_i,
  output logic                  fwd_hit_o,
  output logic [DATA_WIDTH-1:0] fwd_data_o,
  output logic                  fwd_conflict_o,
  output logic                  empty_o,
  output logic                  full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  logic [ADDR_WIDTH-1:0] addr_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_q  [DEPTH];
  logic [1:0]            width_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  logic          push, pop, in_wait;

  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign stu_ready_o = !full_o && !flush_i;
  assign push        = stu_valid_i && stu_ready_o;
  assign in_wait     = (state_q == S_WAIT);
  assign pop         = in_wait && cache_done_i;

  always_comb begin
    head_d = head_q + PW'(pop);
    if (flush_i) begin
      // keep only the in-flight entry; it may retire this same cycle
      tail_d  = head_q + PW'(in_wait);
      count_d = CW'(in_wait && !pop);
    end else begin
      tail_d  = tail_q + PW'(push);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[tail_q]  <= stu_address_i;
      data_q[tail_q]  <= stu_data_i;
      width_q[tail_q] <= stu_width_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (!empty_o && !flush_i) state_d = S_WAIT;
      S_WAIT: if (cache_done_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cache_write_o   = (state_q == S_IDLE) && !empty_o && !flush_i;
    cache_address_o = '0;
    cache_data_o    = '0;
    cache_width_o   = '0;
    if (!empty_o) begin
      cache_address_o = addr_q[head_q];
      cache_data_o    = data_q[head_q];
      cache_width_o   = width_q[head_q];
    end
  end

  logic                  match_any;
  logic                  y_word;
  logic [DATA_WIDTH-1:0] y_data;
  logic [PW-1:0]         idx;

  // oldest to youngest, so the youngest match is left standing
  always_comb begin
    match_any = 1'b0;
    y_word    = 1'b0;
    y_data    = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (CW'(k) < count_q &&
          addr_q[idx][ADDR_WIDTH-1:2] == ldu_address_i[ADDR_WIDTH-1:2]) begin
        match_any = 1'b1;
        y_word    = width_q[idx][1];
        y_data    = data_q[idx];
      end
    end
  end

`ifdef STORE_BUFFER_FORWARDING_EN
  logic fwd_ok;
  assign fwd_ok         = y_word && (ldu_address_i[1:0] == 2'b00);
  assign fwd_hit_o      = ldu_read_i && match_any && fwd_ok;
  assign fwd_data_o     = fwd_hit_o ? y_data : '0;
  assign fwd_conflict_o = ldu_read_i && match_any && !fwd_ok;
`else
  logic unused_fwd;
  assign unused_fwd     = ^{ldu_address_i[1:0], y_word, y_data};
  assign fwd_hit_o      = 1'b0;
  assign fwd_data_o     = '0;
  assign fwd_conflict_o = ldu_read_i && match_any;
`endif
endmodule

// File: tb/tb_data_cache_store_buffer.sv
// Scoreboard bench for data_cache_store_buffer.
// Issue order is checked against a queue filled as stores are pushed.
module tb_data_cache_store_buffer;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        flush = 0;
  logic        stu_valid = 0;
  logic [31:0] stu_address = 0;
  logic [31:0] stu_data = 0;
  logic [1:0]  stu_width = 0;
  logic        stu_ready;
  logic        cache_write;
  logic [31:0] cache_address;
  logic [31:0] cache_data;
  logic [1:0]  cache_width;
  logic        cache_done = 0;
  logic        ldu_read = 0;
  logic [31:0] ldu_address = 0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        fwd_conflict;
  logic        empty;
  logic        full;

  data_cache_store_buffer dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .stu_valid_i(stu_valid), .stu_address_i(stu_address),
    .stu_data_i(stu_data), .stu_width_i(stu_width),
    .stu_ready_o(stu_ready), .cache_write_o(cache_write),
    .cache_address_o(cache_address), .cache_data_o(cache_data),
    .cache_width_o(cache_width), .cache_done_i(cache_done),
    .ldu_read_i(ldu_read), .ldu_address_i(ldu_address),
    .fwd_hit_o(fwd_hit), .fwd_data_o(fwd_data),
    .fwd_conflict_o(fwd_conflict), .empty_o(empty), .full_o(full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  w;
  } st_t;

  st_t exp_q[$];
  int  compared = 0;
  int  mism = 0;
  int  issue_cnt = 0;
  int  done_cnt = 0;

  always @(negedge clk) begin
    if (rst_n && cache_write) begin
      st_t e;
      issue_cnt++;
      compared++;
      if (exp_q.size() == 0) begin
        mism++;
        $display("FAIL issue_unexpected got addr=%h want none", cache_address);
      end else begin
        e = exp_q.pop_front();
        if ({cache_address, cache_data, cache_width} !== {e.a, e.d, e.w}) begin
          mism++;
          $display("FAIL issue_order got %h/%h/%0d want %h/%h/%0d",
                   cache_address, cache_data, cache_width, e.a, e.d, e.w);
        end
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] w);
    st_t e;
    stu_valid = 1; stu_address = a; stu_data = d; stu_width = w;
    e.a = a; e.d = d; e.w = w;
    exp_q.push_back(e);
    @(posedge clk); #1;
    stu_valid = 0;
  endtask

  task automatic do_done();
    int t = 0;
    while (issue_cnt <= done_cnt && t < 50) begin
      @(negedge clk); t++;
    end
    if (issue_cnt <= done_cnt) begin
      compared++; mism++;
      $display("FAIL issue_timeout got none want issue");
    end
    repeat (3) @(posedge clk);
    #1 cache_done = 1;
    @(posedge clk); #1;
    cache_done = 0;
    done_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    compared++;
    if ({stu_ready, empty, full, cache_write, fwd_hit, fwd_conflict} !== 6'b110000 ||
        cache_address !== 0 || cache_data !== 0 || fwd_data !== 0) begin
      mism++;
      $display("FAIL reset_outputs got rdy=%b emp=%b full=%b wr=%b a=%h want 1 1 0 0 0",
               stu_ready, empty, full, cache_write, cache_address);
    end
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    compared++;
    if (empty !== 1 || cache_write !== 0) begin
      mism++;
      $display("FAIL reset_release got emp=%b wr=%b want 1 0", empty, cache_write);
    end
  endtask

  task automatic test_fill();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push(32'h100 + 4 * i, 32'hD000 + i, 2'b10);
    @(negedge clk);
    compared++;
    if (full !== 1 || stu_ready !== 0) begin
      mism++;
      $display("FAIL fill_full got full=%b rdy=%b want 1 0", full, stu_ready);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (issue_cnt !== done_cnt + 1) begin
      mism++;
      $display("FAIL fill_single_issue got %0d want %0d", issue_cnt - done_cnt, 1);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) do_done();
    @(negedge clk);
    compared++;
    if (empty !== 1 || full !== 0) begin
      mism++;
      $display("FAIL drain_empty got emp=%b full=%b want 1 0", empty, full);
    end
  endtask

  task automatic test_push_done_same_cycle();
    st_t e;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push(32'h110 + 4 * i, 32'hE000 + i, 2'b10);
    repeat (2) @(posedge clk); #1;
    stu_valid = 1; stu_address = 32'h140; stu_data = 32'h5A5A; stu_width = 2'b10;
    cache_done = 1;
    @(negedge clk);
    compared++;
    if (stu_ready !== 0 || full !== 1) begin
      mism++;
      $display("FAIL pushdone_refused got rdy=%b full=%b want 0 1", stu_ready, full);
    end
    @(posedge clk); #1;
    cache_done = 0; done_cnt++;
    @(negedge clk);
    compared++;
    if (stu_ready !== 1 || full !== 0) begin
      mism++;
      $display("FAIL pushdone_count3 got rdy=%b full=%b want 1 0", stu_ready, full);
    end
    e.a = 32'h140; e.d = 32'h5A5A; e.w = 2'b10;
    exp_q.push_back(e);
    @(posedge clk); #1;
    stu_valid = 0;
    @(negedge clk);
    compared++;
    if (full !== 1) begin
      mism++;
      $display("FAIL pushdone_accept got full=%b want 1", full);
    end
    for (int i = 0; i < 4; i++) do_done();
  endtask

  task automatic test_forwarding();
    logic        want_hit;
    logic [31:0] want_data;
`ifdef STORE_BUFFER_FORWARDING_EN
    want_hit = 1; want_data = 32'hAABBCCDD;
`else
    want_hit = 0; want_data = 0;
`endif
    @(posedge clk); #1;
    push(32'h200, 32'hAABBCCDD, 2'b10);
    ldu_read = 1; ldu_address = 32'h200;
    @(negedge clk);
    compared++;
    if (fwd_hit !== want_hit || fwd_data !== want_data || fwd_conflict !== !want_hit) begin
      mism++;
      $display("FAIL fwd_word got h=%b d=%h c=%b want %b %h %b",
               fwd_hit, fwd_data, fwd_conflict, want_hit, want_data, !want_hit);
    end
    ldu_address = 32'h300;
    @(negedge clk);
    compared++;
    if (fwd_hit !== 0 || fwd_conflict !== 0) begin
      mism++;
      $display("FAIL fwd_nomatch got h=%b c=%b want 0 0", fwd_hit, fwd_conflict);
    end
    @(posedge clk); #1;
    push(32'h201, 32'h11, 2'b00);
    ldu_address = 32'h200;
    @(negedge clk);
    compared++;
    if (fwd_hit !== 0 || fwd_conflict !== 1 || fwd_data !== 0) begin
      mism++;
      $display("FAIL fwd_byte_conflict got h=%b c=%b d=%h want 0 1 0",
               fwd_hit, fwd_conflict, fwd_data);
    end
    ldu_read = 0;
    @(negedge clk);
    compared++;
    if (fwd_hit !== 0 || fwd_conflict !== 0) begin
      mism++;
      $display("FAIL fwd_noread got h=%b c=%b want 0 0", fwd_hit, fwd_conflict);
    end
    for (int i = 0; i < 2; i++) do_done();
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) push(32'h400 + 4 * i, 32'hF000 + i, 2'b10);
    flush = 1; stu_valid = 1; stu_address = 32'h4F0;
    @(negedge clk);
    compared++;
    if (stu_ready !== 0 || cache_write !== 0) begin
      mism++;
      $display("FAIL flush_refuse got rdy=%b wr=%b want 0 0", stu_ready, cache_write);
    end
    @(posedge clk); #1;
    flush = 0; stu_valid = 0;
    exp_q.delete();
    @(negedge clk);
    compared++;
    if (empty !== 0 || cache_address !== 32'h400) begin
      mism++;
      $display("FAIL flush_keep_inflight got emp=%b a=%h want 0 400", empty, cache_address);
    end
    @(posedge clk); #1 cache_done = 1;
    @(posedge clk); #1 cache_done = 0;
    done_cnt++;
    @(negedge clk);
    compared++;
    if (empty !== 1) begin
      mism++;
      $display("FAIL flush_empty got %b want 1", empty);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) push(32'h500 + 4 * i, 32'h7000 + i, 2'b01);
    #2 rst_n = 0;
    exp_q.delete();
    @(negedge clk);
    done_cnt = issue_cnt;
    compared++;
    if (empty !== 1 || cache_write !== 0 || stu_ready !== 1 || full !== 0) begin
      mism++;
      $display("FAIL reset_wait got emp=%b wr=%b rdy=%b want 1 0 1",
               empty, cache_write, stu_ready);
    end
    @(posedge clk); #1 rst_n = 1;
    repeat (3) @(negedge clk);
    compared++;
    if (empty !== 1 || cache_write !== 0) begin
      mism++;
      $display("FAIL reset_wait_after got emp=%b wr=%b want 1 0", empty, cache_write);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_push_done_same_cycle();
    test_forwarding();
    test_flush();
    test_reset_mid_wait();
    compared++;
    if (exp_q.size() != 0) begin
      mism++;
      $display("FAIL leftover_expected got %0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
